// File: rtl/capture_sequencer.sv
// capture_sequencer: pre/post-trigger capture into a circular sample buffer, then an oldest-first readout stream.
// Optional feature macro CAPSEQ_DECIMATE_EN: sample enable once every 2^div cycles, div latched on start.
module capture_sequencer #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic [$clog2(DEPTH)-1:0] post_len,
  input  logic [WIDTH-1:0]         sample_in,
  input  logic                     trig_hit,
  input  logic [1:0]               div,
  output logic                     arm,
  output logic                     busy,
  output logic                     done,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  output logic                     rd_last,
  input  logic                     rd_ready,
  output logic [$clog2(DEPTH)-1:0] trig_pos
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {IDLE, FILL, ARMED, POST, READ} state_t;

  state_t           state, state_next;
  logic [AW-1:0]    wr_ptr, rd_ptr, cnt, pre_q, post_q;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             se, wr_en;

`ifdef CAPSEQ_DECIMATE_EN
  logic [2:0] presc;
  logic [2:0] presc_mask;
  logic [1:0] div_q;

  always_comb begin
    case (div_q)
      2'd0:    presc_mask = 3'b000;
      2'd1:    presc_mask = 3'b001;
      2'd2:    presc_mask = 3'b011;
      default: presc_mask = 3'b111;
    endcase
  end

  assign se = ((presc & presc_mask) == 3'b000);

  // Prescaler is held at zero in IDLE so the first capture cycle always samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= 3'b000;
      div_q <= 2'd0;
    end else if (state == IDLE) begin
      presc <= 3'b000;
      if (start && !abort) div_q <= div;
    end else begin
      presc <= presc + 3'd1;
    end
  end
`else
  logic unused_div;
  assign unused_div = ^div;
  assign se         = 1'b1;
`endif

  assign trig_pos = pre_q;
  assign rd_data  = mem[rd_ptr];

  always_comb begin
    state_next = state;
    arm        = 1'b0;
    busy       = (state != IDLE);
    done       = 1'b0;
    rd_valid   = 1'b0;
    rd_last    = 1'b0;
    wr_en      = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) state_next = FILL;
      end
      FILL: begin
        wr_en = se;
        if (pre_q == '0) state_next = ARMED;
        else if (se && cnt == pre_q - AW'(1)) state_next = ARMED;
      end
      ARMED: begin
        arm   = 1'b1;
        wr_en = se;
        if (se && trig_hit) begin
          if (post_q == '0) begin
            done       = 1'b1;
            state_next = READ;
          end else begin
            state_next = POST;
          end
        end
      end
      POST: begin
        wr_en = se;
        if (se && cnt == post_q - AW'(1)) begin
          done       = 1'b1;
          state_next = READ;
        end
      end
      READ: begin
        rd_valid = 1'b1;
        rd_last  = (rd_ptr + AW'(1) == wr_ptr);
        if (rd_ready && rd_last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // abort overrides everything, including the completing write and its done pulse
    if (abort && state != IDLE) begin
      state_next = IDLE;
      done       = 1'b0;
      wr_en      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      pre_q  <= '0;
      post_q <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
        if (start && !abort) begin
          post_q <= post_len;
          pre_q  <= ~post_len;
        end
      end else begin
        if (wr_en) wr_ptr <= wr_ptr + AW'(1);
        if (state == ARMED) cnt <= '0;
        else if (wr_en) cnt <= cnt + AW'(1);
        // Entry into READ coincides with the final write, so the oldest entry is one past wr_ptr.
        if (state != READ && state_next == READ) rd_ptr <= wr_ptr + AW'(1);
        else if (state == READ && rd_ready) rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= sample_in;
  end

endmodule

// File: doc/capture_sequencer.md
CAPTURE_SEQUENCER -- requirements
Module: capture_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 4, sample width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, sample buffer entries; power of two, >= 4.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  begin capture; sampled only in IDLE.
REQ-006 SHALL have port abort  input  1  cancel the current capture or readout.
REQ-007 SHALL have port post_len  input  log2(DEPTH)  post-trigger sample count, 0..DEPTH-1; latched on start.
REQ-008 SHALL have port sample_in  input  WIDTH  channel data written to the buffer.
REQ-009 SHALL have port trig_hit  input  1  edge-match pulse from the trigger block.
REQ-010 SHALL have port div  input  2  decimation exponent; used only when CAPSEQ_DECIMATE_EN is defined.
REQ-011 SHALL have port arm  output  1  drives the arm input of the trigger block.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.
REQ-013 SHALL have port done  output  1  one-cycle pulse when capture completes.
REQ-014 SHALL have port rd_data / rd_valid / rd_last  output  WIDTH/1/1  readout stream.
REQ-015 SHALL have port rd_ready  input  1  readout stream accept.
REQ-016 SHALL have port trig_pos  output  log2(DEPTH)  readout index of the trigger sample, equal to DEPTH-1-post_len.

Function
REQ-017 SHALL implement the states IDLE, FILL, ARMED, POST and READ.
REQ-018 SHALL write sample_in to buf[wr_ptr] on every sample-enable (se) cycle in FILL, ARMED and POST, and SHALL then increment wr_ptr modulo DEPTH.
REQ-019 SHALL leave IDLE for FILL on start, with the pre-trigger count pre = DEPTH-1-post_len and wr_ptr = 0.
REQ-020 SHALL move from FILL to ARMED after pre se-writes; when pre = 0, the move SHALL occur on the first cycle.
REQ-021 SHALL drive arm = 1 only in ARMED.
REQ-022 SHALL ignore trig_hit outside ARMED or on cycles without se.
REQ-023 In ARMED, trig_hit with se SHALL write the trigger sample and then enter POST; when post_len = 0, it SHALL pulse done and enter READ instead.
REQ-024 In POST, after post_len se-writes, SHALL pulse done and enter READ.
REQ-025 In READ, rd_ptr SHALL start at wr_ptr (the oldest entry), and rd_valid = 1 with rd_data = buf[rd_ptr] combinationally.
REQ-026 A readout transfer SHALL occur when rd_valid and rd_ready are both high; rd_ptr SHALL then increment modulo DEPTH.
REQ-027 rd_data SHALL hold stable while rd_valid is high and rd_ready is low.
REQ-028 rd_last SHALL be high on the DEPTH-th beat; that beat's transfer SHALL return the block to IDLE.
REQ-029 abort in any non-IDLE state SHALL return the block to IDLE on the next edge, with arm = 0, rd_valid = 0 and no done pulse.
REQ-030 When abort and start occur in the same IDLE cycle, abort SHALL win.
REQ-031 start outside IDLE SHALL be ignored.
REQ-032 Changes to post_len during a capture SHALL be ignored.
REQ-033 done SHALL not be asserted in the same cycle as rd_valid.

Reset
REQ-034 While rst = 1, the block SHALL be in IDLE with arm, busy, done, rd_valid, rd_last, wr_ptr, rd_ptr and the prescaler all at 0.
REQ-035 Buffer contents SHALL not be reset.
REQ-036 rst mid-capture or mid-readout SHALL return the block to IDLE immediately, without any further output activity.

Configuration
REQ-037 With CAPSEQ_DECIMATE_EN defined, se SHALL be high once every 2^div cycles; the prescaler SHALL clear on start and div SHALL be latched on start.
REQ-038 With CAPSEQ_DECIMATE_EN undefined, se SHALL be 1 every cycle, div SHALL be ignored, and no prescaler logic SHALL exist.

Verification
REQ-039 Bench SHALL cover: post_len = 4, sample_in = counter, trig_hit on sample 0x9 -> 16 beats starting at 0xF−… from oldest, trig_pos = 11, beat 11 = 0x9, rd_last on beat 16.
REQ-040 Bench SHALL cover: post_len = 0 with trig_hit -> done on the trigger cycle's edge, trigger sample is the last beat, trig_pos = 15.
REQ-041 Bench SHALL cover: trig_hit pulses during FILL -> ignored; arm = 0 until pre writes complete.
REQ-042 Bench SHALL cover: rd_ready toggled 1-0-0-1 -> rd_data held while stalled, exactly 16 beats, no repeated or dropped values.
REQ-043 Bench SHALL cover: abort in POST, then start in the next cycle -> IDLE, no done pulse, a new capture begins with wr_ptr = 0.
REQ-044 Bench SHALL cover, with CAPSEQ_DECIMATE_EN and div = 2: sample_in = cycle count -> buffered values step by 4; trig_hit on a non-se cycle is ignored.
